// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin arbiter sharing one CORDIC core between two
// requesters. Accepts one angle at a time, starts the core, waits for its
// result and returns it on a valid/ready response port tagged with the id.
// Optional core watchdog enabled by defining CORDIC_ARB_TIMEOUT_EN.
module cordic_arbiter #(
  parameter int unsigned DATA_W     = 22,
  parameter int unsigned TMO_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_angle,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_angle,
  output logic              req1_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_cos,
  output logic              rsp_id,
  output logic              rsp_err,
  output logic              core_start,
  output logic [DATA_W-1:0] core_angle,
  input  logic [DATA_W-1:0] core_cos,
  input  logic              core_done,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              core_start_q, core_start_d;
  logic [DATA_W-1:0] core_angle_q, core_angle_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_cos_q, rsp_cos_d;
  logic              rsp_id_q, rsp_id_d;
  logic              busy_q, busy_d;
  logic              gnt_valid, gnt_id;

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int unsigned WDOG_W = (TMO_CYCLES < 2) ? 1 : $clog2(TMO_CYCLES);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              rsp_err_q, rsp_err_d;
`endif

  // Round-robin grant, only offered while idle and out of reset
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (state_q == S_IDLE && !reset) begin
      if (req0_valid && req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = ptr_q;
      end else if (req0_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end else if (req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
    end
  end

  assign req0_ready = gnt_valid & ~gnt_id;
  assign req1_ready = gnt_valid &  gnt_id;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    core_start_d = 1'b0;
    core_angle_d = core_angle_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_cos_d    = rsp_cos_q;
    rsp_id_d     = rsp_id_q;
`ifdef CORDIC_ARB_TIMEOUT_EN
    wdog_d       = wdog_q;
    rsp_err_d    = rsp_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          state_d      = S_START;
          core_start_d = 1'b1;
          core_angle_d = gnt_id ? req1_angle : req0_angle;
          rsp_id_d     = gnt_id;
          ptr_d        = ~gnt_id;
`ifdef CORDIC_ARB_TIMEOUT_EN
          rsp_err_d    = 1'b0;
`endif
        end
      end
      S_START: begin
        // core_done is deliberately ignored here
        state_d = S_WAIT;
`ifdef CORDIC_ARB_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      S_WAIT: begin
        if (core_done) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_cos_d   = core_cos;
`ifdef CORDIC_ARB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (wdog_q == WDOG_W'(TMO_CYCLES - 1)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_cos_d   = '0;
          rsp_err_d   = 1'b1;
        end else begin
          wdog_d      = wdog_q + WDOG_W'(1);
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= 1'b0;
      core_start_q <= 1'b0;
      core_angle_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_cos_q    <= '0;
      rsp_id_q     <= 1'b0;
      busy_q       <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      wdog_q       <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      core_start_q <= core_start_d;
      core_angle_q <= core_angle_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_cos_q    <= rsp_cos_d;
      rsp_id_q     <= rsp_id_d;
      busy_q       <= busy_d;
`ifdef CORDIC_ARB_TIMEOUT_EN
      wdog_q       <= wdog_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign core_start = core_start_q;
  assign core_angle = core_angle_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_cos    = rsp_cos_q;
  assign rsp_id     = rsp_id_q;
  assign busy       = busy_q;
`ifdef CORDIC_ARB_TIMEOUT_EN
  assign rsp_err    = rsp_err_q;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_arbiter.sv
// Self-checking bench for cordic_arbiter with a behavioural CORDIC core stand-in
// and a transaction-level reference model. Honours CORDIC_ARB_TIMEOUT_EN.
module tb_cordic_arbiter;
  localparam int unsigned DW       = 22;
  localparam int          CORE_LAT = 17;  // core_done comes CORE_LAT cycles after the core_start cycle
  localparam int          RSP_LAT  = 19;  // transfer cycle to rsp_valid
  localparam int          TMO      = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [DW-1:0] req0_angle = '0, req1_angle = '0;
  logic          req0_ready, req1_ready;
  logic          rsp_valid, rsp_id, rsp_err;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_cos;
  logic          core_start, core_done, busy;
  logic [DW-1:0] core_angle, core_cos;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  cordic_arbiter #(.DATA_W(DW), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_angle(req0_angle), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_angle(req1_angle), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_cos(rsp_cos),
    .rsp_id(rsp_id), .rsp_err(rsp_err),
    .core_start(core_start), .core_angle(core_angle), .core_cos(core_cos),
    .core_done(core_done), .busy(busy)
  );

  // Stand-in "cosine": any fixed bijection of the angle serves to tag results
  function automatic logic [DW-1:0] cos_of(input logic [DW-1:0] a);
    logic [DW-1:0] r;
    r = {a[10:0], a[21:11]} ^ 22'h15A5A5;
    return r + 22'd3;
  endfunction

  // Shared core model: not reset by the arbiter's reset
  logic [DW-1:0] core_lat_angle = '0;
  int            core_cnt = 0;
  logic          core_stuck = 1'b0;
  logic          done_inj = 1'b0;
  always @(posedge clk) begin
    if (core_start) begin
      core_lat_angle <= core_angle;
      core_cnt       <= CORE_LAT;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
    end
  end
  assign core_done = ((core_cnt == 1) && !core_stuck) || done_inj;
  assign core_cos  = cos_of(core_lat_angle);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1;
    tick(); tick();
    vectors++; if ({core_start, rsp_valid, rsp_id, rsp_err, busy} !== 5'b0) begin errors++;
      $display("FAIL reset_flags: got %b want 00000", {core_start, rsp_valid, rsp_id, rsp_err, busy}); end
    vectors++; if (core_angle !== '0) begin errors++; $display("FAIL reset_core_angle: got %0h want 0", core_angle); end
    vectors++; if (rsp_cos !== '0) begin errors++; $display("FAIL reset_rsp_cos: got %0h want 0", rsp_cos); end
    vectors++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++;
      $display("FAIL reset_ready: got %b want 00", {req1_ready, req0_ready}); end
    req0_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    tick();
    req0_valid = 1'b1; req0_angle = '0; rsp_ready = 1'b0;
    #1;
    vectors++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++;
      $display("FAIL single_grant: got %b want 01", {req1_ready, req0_ready}); end
    tick();  // cycle 1: START, stray core_done must be ignored
    req0_valid = 1'b0; done_inj = 1'b1;
    vectors++; if ({core_start, busy} !== 2'b11) begin errors++;
      $display("FAIL single_start: got %b want 11", {core_start, busy}); end
    vectors++; if (core_angle !== '0) begin errors++; $display("FAIL single_core_angle: got %0h want 0", core_angle); end
    tick();  // cycle 2
    done_inj = 1'b0;
    vectors++; if (core_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse: got %b want 0", core_start); end
    for (int c = 3; c < RSP_LAT; c++) begin
      tick();
      vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp: cycle %0d got 1 want 0", c); end
    end
    tick();  // cycle 19
    vectors++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b100) begin errors++;
      $display("FAIL single_rsp: got %b want 100", {rsp_valid, rsp_id, rsp_err}); end
    vectors++; if (rsp_cos !== cos_of('0)) begin errors++;
      $display("FAIL single_rsp_cos: got %0h want %0h", rsp_cos, cos_of('0)); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vectors++; if ({rsp_valid, busy} !== 2'b00) begin errors++;
      $display("FAIL single_after: got %b want 00", {rsp_valid, busy}); end
  endtask

  task automatic test_hold();
    logic [DW-1:0] a, b;
    a = DW'($urandom); b = DW'($urandom);
    do_reset();
    tick();
    req0_valid = 1'b1; req0_angle = a; rsp_ready = 1'b0;
    #1;
    vectors++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL hold_grant0: got %b want 1", req0_ready); end
    for (int c = 1; c < RSP_LAT + 10; c++) begin
      tick();
      if (c == 1) begin req0_valid = 1'b0; req1_valid = 1'b1; req1_angle = b; end
      #1;
      vectors++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL hold_req1_ready: cycle %0d got 1 want 0", c); end
      if (c >= RSP_LAT) begin
        vectors++; if ({rsp_valid, rsp_id} !== 2'b10 || rsp_cos !== cos_of(a)) begin errors++;
          $display("FAIL hold_stable: cycle %0d got v=%b id=%b cos=%0h want v=1 id=0 cos=%0h",
                   c, rsp_valid, rsp_id, rsp_cos, cos_of(a)); end
      end
    end
    rsp_ready = 1'b1;
    tick();  // back in IDLE: pending req1 now granted
    rsp_ready = 1'b0;
    #1;
    vectors++; if ({rsp_valid, req1_ready} !== 2'b01) begin errors++;
      $display("FAIL hold_release: got %b want 01", {rsp_valid, req1_ready}); end
    for (int c = 1; c <= RSP_LAT; c++) begin
      tick();
      if (c == 1) req1_valid = 1'b0;
    end
    vectors++; if ({rsp_valid, rsp_id} !== 2'b11 || rsp_cos !== cos_of(b)) begin errors++;
      $display("FAIL hold_second: got v=%b id=%b cos=%0h want v=1 id=1 cos=%0h", rsp_valid, rsp_id, rsp_cos, cos_of(b)); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // Transaction-level model: per-requester FIFOs, round-robin pointer, one
  // outstanding job, fixed response latency, results in acceptance order.
  task automatic run_traffic(input string tag, input int n_cycles, input bit saturate, input int min_grants);
    logic [DW-1:0] q0[$], q1[$];
    bit            inflight = 1'b0;
    bit            ptr = 1'b0;
    bit            g;
    int            t_x = 0, ngrant = 0;
    logic          exp_id = 1'b0;
    logic [DW-1:0] exp_cos = '0;
    do_reset();
    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      tick();
      if (saturate) begin
        if (q0.size() == 0) q0.push_back(DW'($urandom));
        if (q1.size() == 0) q1.push_back(DW'($urandom));
        rsp_ready = 1'b1;
      end else begin
        if (q0.size() < 4 && $urandom_range(0, 3) == 0) q0.push_back(DW'($urandom));
        if (q1.size() < 4 && $urandom_range(0, 3) == 0) q1.push_back(DW'($urandom));
        rsp_ready = 1'($urandom_range(0, 1));
      end
      req0_valid = (q0.size() > 0); req0_angle = req0_valid ? q0[0] : DW'($urandom);
      req1_valid = (q1.size() > 0); req1_angle = req1_valid ? q1[0] : DW'($urandom);
      #1;
      if (inflight) begin
        vectors++; if ({req1_ready, req0_ready, busy} !== 3'b001) begin errors++;
          $display("FAIL %s_busy: cycle %0d got rdy=%b busy=%b want rdy=00 busy=1", tag, cyc, {req1_ready, req0_ready}, busy); end
        vectors++; if (rsp_valid !== (cyc - t_x >= RSP_LAT)) begin errors++;
          $display("FAIL %s_rsp_valid: cycle %0d got %b want %b", tag, cyc, rsp_valid, (cyc - t_x >= RSP_LAT)); end
        if (rsp_valid === 1'b1 && cyc - t_x >= RSP_LAT) begin
          vectors++; if ({rsp_id, rsp_err} !== {exp_id, 1'b0} || rsp_cos !== exp_cos) begin errors++;
            $display("FAIL %s_rsp_data: cycle %0d got id=%b err=%b cos=%0h want id=%b err=0 cos=%0h",
                     tag, cyc, rsp_id, rsp_err, rsp_cos, exp_id, exp_cos); end
          if (rsp_ready) inflight = 1'b0;
        end
      end else begin
        g = (req0_valid && req1_valid) ? ptr : req1_valid;
        vectors++; if ({rsp_valid, busy} !== 2'b00) begin errors++;
          $display("FAIL %s_idle: cycle %0d got v=%b busy=%b want 00", tag, cyc, rsp_valid, busy); end
        vectors++; if ({req1_ready, req0_ready} !== {(req0_valid || req1_valid) && g, (req0_valid || req1_valid) && !g}) begin errors++;
          $display("FAIL %s_grant: cycle %0d got %b want %b", tag, cyc, {req1_ready, req0_ready},
                   {(req0_valid || req1_valid) && g, (req0_valid || req1_valid) && !g}); end
        if (req0_valid || req1_valid) begin
          exp_cos  = cos_of(g ? q1.pop_front() : q0.pop_front());
          exp_id   = g;
          ptr      = !g;
          inflight = 1'b1;
          t_x      = cyc;
          ngrant++;
        end
      end
    end
    vectors++; if (ngrant < min_grants) begin errors++;
      $display("FAIL %s_progress: got %0d grants want at least %0d", tag, ngrant, min_grants); end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_traffic("b2b", 200, 1'b1, 9);
  endtask

  task automatic test_random();
    run_traffic("rand", 1500, 1'b0, 30);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] a;
    int            first;
    a = DW'($urandom) | DW'(1);
    do_reset();
    tick();
    req1_valid = 1'b1; req1_angle = a;
    #1;
    vectors++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL rmid_grant: got %b want 1", req1_ready); end
    for (int c = 1; c <= 8; c++) begin
      tick();
      req1_valid = 1'b0;
    end
    reset = 1'b1;  // cycle 8, DUT in WAIT
    #1;
    vectors++; if ({core_start, rsp_valid, rsp_id, rsp_err, busy} !== 5'b0 || core_angle !== '0 || rsp_cos !== '0) begin errors++;
      $display("FAIL rmid_async: got flags=%b angle=%0h cos=%0h want 0", {core_start, rsp_valid, rsp_id, rsp_err, busy}, core_angle, rsp_cos); end
    tick();
    reset = 1'b0;
    for (int c = 10; c <= 30; c++) begin  // late core_done at cycle 18 must be ignored
      tick();
      vectors++; if ({rsp_valid, busy} !== 2'b00) begin errors++;
        $display("FAIL rmid_after: cycle %0d got %b want 00", c, {rsp_valid, busy}); end
    end
    req0_valid = 1'b1; req0_angle = ~a;
    #1;
    vectors++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rmid_regrant: got %b want 1", req0_ready); end
    first = -1;
    for (int c = 1; c <= 40 && first < 0; c++) begin
      tick();
      req0_valid = 1'b0;
      if (rsp_valid === 1'b1) first = c;
    end
    vectors++; if (first != RSP_LAT || rsp_id !== 1'b0 || rsp_cos !== cos_of(~a)) begin errors++;
      $display("FAIL rmid_recover: got cycle=%0d id=%b cos=%0h want cycle=%0d id=0 cos=%0h", first, rsp_id, rsp_cos, RSP_LAT, cos_of(~a)); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    logic exp_v;
    do_reset();
    core_stuck = 1'b1;
    tick();
    req0_valid = 1'b1; req0_angle = DW'($urandom);
    #1;
    vectors++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL tmo_grant: got %b want 1", req0_ready); end
    for (int c = 1; c <= 60; c++) begin
      tick();
      req0_valid = 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      exp_v = (c >= TMO + 2);
`else
      exp_v = 1'b0;
`endif
      vectors++; if (rsp_valid !== exp_v) begin errors++;
        $display("FAIL tmo_valid: cycle %0d got %b want %b", c, rsp_valid, exp_v); end
      if (exp_v) begin
        vectors++; if (rsp_err !== 1'b1 || rsp_cos !== '0 || rsp_id !== 1'b0) begin errors++;
          $display("FAIL tmo_data: cycle %0d got err=%b cos=%0h id=%b want err=1 cos=0 id=0", c, rsp_err, rsp_cos, rsp_id); end
      end
    end
    core_stuck = 1'b0;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 22, angle/cosine word width.
REQ-002 SHALL have parameter TMO_CYCLES, default 32, core watchdog limit in cycles (used only with CORDIC_ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1 each  requester has an angle pending.
REQ-006 SHALL have ports req0_angle/req1_angle  input  DATA_W each  requester angle.
REQ-007 SHALL have ports req0_ready/req1_ready  output  1 each  request accepted this cycle.
REQ-008 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_cos  output  DATA_W, rsp_id  output  1 (requester index), rsp_err  output  1 (timeout flag).
REQ-009 SHALL have ports core_start  output  1, core_angle  output  DATA_W, core_cos  input  DATA_W, core_done  input  1  shared CORDIC core.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL implement FSM IDLE -> START -> WAIT -> RESP -> IDLE.
REQ-012 In IDLE, SHALL assert at most one reqN_ready, combinationally, for the granted valid requester; a transfer is valid&ready.
REQ-013 Arbitration SHALL be round-robin: pointer selects preferred requester; if only one valid, it is granted; after each grant pointer SHALL point to the other requester.
REQ-014 On transfer, SHALL register angle and requester index, then go to START.
REQ-015 In START, SHALL assert core_start for exactly one cycle with core_angle = latched angle; core_start SHALL be 0 in all other states.
REQ-016 core_angle SHALL hold the latched angle from START until the next transfer.
REQ-017 SHALL ignore core_done in START; in WAIT, first cycle with core_done=1 SHALL capture core_cos into rsp_cos and go to RESP.
REQ-018 With a 16-iteration core, rsp_valid SHALL rise 19 cycles after the transfer cycle (transfer = cycle 0).
REQ-019 In RESP, rsp_valid, rsp_cos, rsp_id, rsp_err SHALL be held stable until rsp_valid&rsp_ready, then go to IDLE; no new request accepted in the handshake cycle.
REQ-020 Requests arriving in START/WAIT/RESP SHALL see ready=0 and remain pending; no request is dropped or duplicated.
REQ-021 rsp_valid SHALL never be asserted outside RESP.

Reset
REQ-022 reset SHALL asynchronously force IDLE, pointer=0, core_start=0, rsp_valid=0, rsp_cos=0, rsp_id=0, rsp_err=0, core_angle=0, busy=0, watchdog=0.
REQ-023 Reset mid-operation SHALL abandon the in-flight request with no response; a core_done arriving after reset deassertion in IDLE SHALL be ignored.

Configuration
REQ-024 Macro CORDIC_ARB_TIMEOUT_EN defined: watchdog counts WAIT cycles; on reaching TMO_CYCLES without core_done, SHALL go to RESP with rsp_err=1, rsp_cos=0; counter clears on entry to WAIT.
REQ-025 Macro undefined: no counter in RTL, WAIT lasts until core_done, rsp_err tied to 0.

Verification
REQ-026 Single req0, angle 22'h0 -> req0_ready cycle 0, core_start cycle 1, rsp_valid cycle 19, rsp_id=0, rsp_cos = core output, rsp_err=0.
REQ-027 req0 and req1 valid together continuously, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence matches; no grant while busy=1.
REQ-028 rsp_ready held 0 for 10 cycles in RESP -> rsp_valid/rsp_cos/rsp_id stable 10 cycles; req1_valid=1 meanwhile sees ready=0 until IDLE.
REQ-029 reset pulsed during WAIT (cycle 8) -> all outputs at reset values same cycle; no rsp_valid afterwards; next request completes normally.
REQ-030 CORDIC_ARB_TIMEOUT_EN, TMO_CYCLES=32, core_done stuck 0 -> rsp_valid with rsp_err=1, rsp_cos=0 after 32 WAIT cycles; without macro, rsp_valid stays 0.
